text_stream_writer: RTL and testbench

- Upstream of the text screen generator. Converts a byte stream (UART RX or keyboard decoder) into write cycles for the 40x20 tile RAM.
- Owns the write cursor. Handles printable characters, control codes (CR, LF, BS, FF) and row/screen blanking.
- Drives the tile RAM write port: we, addr_w, din. Exports cursor position for the reverse-video cursor.

---
 rtl/text_stream_writer.sv | 159 +++++++++++++++
 tb/tb_text_stream_writer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/text_stream_writer.sv
// Byte-stream to tile RAM writer: owns the write cursor, decodes printable and control
// bytes, and runs row / full-screen blanking sweeps through the registered write port.
//
// state  | meaning
// IDLE   | accepting bytes; services a pending clear first
// ROWCLR | blanking all columns of row cur_y after a line advance
// SCRCLR | blanking every cell row-major, then cursor returns home
module text_stream_writer #(
  parameter int         MAX_X = 40,
  parameter int         MAX_Y = 20,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        clear,
  output logic        we,
  output logic [11:0] addr_w,
  output logic [6:0]  din,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy
);

  localparam int         CNT_W   = $clog2(MAX_X * MAX_Y + 1);
  localparam logic [6:0] X_LAST  = 7'(MAX_X - 1);
  localparam logic [4:0] Y_LAST  = 5'(MAX_Y - 1);
  localparam logic [CNT_W-1:0] ROW_CNT = CNT_W'(MAX_X);
  localparam logic [CNT_W-1:0] SCR_CNT = CNT_W'(MAX_X * MAX_Y);

  typedef enum logic [1:0] {IDLE, ROWCLR, SCRCLR} state_t;

  state_t           state;
  logic             clear_pending;
  logic             clear_req;
  logic [CNT_W-1:0] sweep_cnt;
  logic [6:0]       sweep_x;
  logic [4:0]       sweep_y;
  logic [4:0]       next_y;
  logic             printable;

  // A clear arriving in the same cycle already blocks the byte.
  assign clear_req = clear_pending | clear;
  assign rx_ready  = (state == IDLE) && !clear_req;
  assign next_y    = (cur_y == Y_LAST) ? 5'd0 : cur_y + 5'd1;
  assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
      sweep_cnt     <= '0;
      sweep_x       <= '0;
      sweep_y       <= '0;
      we            <= 1'b0;
      addr_w        <= '0;
      din           <= '0;
      cur_x         <= '0;
      cur_y         <= '0;
      busy          <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (clear_req) begin
            clear_pending <= 1'b0;
            state         <= SCRCLR;
            busy          <= 1'b1;
            sweep_cnt     <= SCR_CNT;
            sweep_x       <= '0;
            sweep_y       <= '0;
          end else if (rx_valid && !rx_data[7]) begin
            if (printable) begin
              we     <= 1'b1;
              addr_w <= {cur_y, cur_x};
              din    <= rx_data[6:0];
              if (cur_x != X_LAST) begin
                cur_x <= cur_x + 7'd1;
              end else begin
                cur_x     <= '0;
                cur_y     <= next_y;
                state     <= ROWCLR;
                busy      <= 1'b1;
                sweep_cnt <= ROW_CNT;
                sweep_x   <= '0;
              end
            end else begin
              case (rx_data)
                8'h0D: cur_x <= '0;
                8'h0A: begin
                  cur_x     <= '0;
                  cur_y     <= next_y;
                  state     <= ROWCLR;
                  busy      <= 1'b1;
                  sweep_cnt <= ROW_CNT;
                  sweep_x   <= '0;
                end
                8'h08: begin
                  if (cur_x != 7'd0) begin
                    cur_x  <= cur_x - 7'd1;
                    we     <= 1'b1;
                    addr_w <= {cur_y, cur_x - 7'd1};
                    din    <= BLANK;
                  end
                end
                8'h0C: begin
                  state     <= SCRCLR;
                  busy      <= 1'b1;
                  sweep_cnt <= SCR_CNT;
                  sweep_x   <= '0;
                  sweep_y   <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        ROWCLR: begin
          if (sweep_cnt != '0) begin
            we        <= 1'b1;
            addr_w    <= {cur_y, sweep_x};
            din       <= BLANK;
            sweep_x   <= sweep_x + 7'd1;
            sweep_cnt <= sweep_cnt - 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SCRCLR: begin
          if (sweep_cnt != '0) begin
            we        <= 1'b1;
            addr_w    <= {sweep_y, sweep_x};
            din       <= BLANK;
            sweep_cnt <= sweep_cnt - 1'b1;
            if (sweep_x == X_LAST) begin
              sweep_x <= '0;
              sweep_y <= sweep_y + 5'd1;
            end else begin
              sweep_x <= sweep_x + 7'd1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            cur_x <= '0;
            cur_y <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      // Clears seen outside IDLE queue exactly one further full clear.
      if (state != IDLE && clear) clear_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_text_stream_writer.sv
// Directed bench for text_stream_writer: cursor moves, control codes, row and screen sweeps,
// clear queuing and asynchronous reset mid-sweep, against hand-computed expectations.
module tb_text_stream_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        clear = 1'b0;
  logic        we;
  logic [11:0] addr_w;
  logic [6:0]  din;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  int tests_run = 0;
  int fails = 0;

  text_stream_writer dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .clear(clear), .we(we), .addr_w(addr_w), .din(din), .cur_x(cur_x), .cur_y(cur_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one byte for one cycle; returns in the cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !rx_ready) && n < 2000) begin step(); n++; end
    tests_run++;
    if (busy || !rx_ready) begin fails++; $display("FAIL wait_idle timeout busy=%0b rx_ready=%0b", busy, rx_ready); end
  endtask

  task automatic test_reset();
    reset = 1'b0; step(); step();
    reset = 1'b1; step();
    tests_run++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we got %0b want 0", we); end
    tests_run++; if (addr_w !== 12'h000 || din !== 7'h00) begin fails++; $display("FAIL reset_addr_din got %h/%h want 000/00", addr_w, din); end
    tests_run++; if (cur_x !== 7'd0 || cur_y !== 5'd0) begin fails++; $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    tests_run++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin fails++; $display("FAIL reset_flags busy=%0b rx_ready=%0b want 0/1", busy, rx_ready); end
  endtask

  task automatic test_printable();
    send_byte(8'h41);
    tests_run++; if (we !== 1'b1 || addr_w !== 12'h000 || din !== 7'h41) begin fails++; $display("FAIL char_write got we=%0b addr=%h din=%h want 1/000/41", we, addr_w, din); end
    tests_run++; if (cur_x !== 7'd1 || cur_y !== 5'd0) begin fails++; $display("FAIL char_cursor got (%0d,%0d) want (1,0)", cur_x, cur_y); end
    step();
    tests_run++; if (we !== 1'b0 || rx_ready !== 1'b1) begin fails++; $display("FAIL char_single_we got we=%0b rx_ready=%0b want 0/1", we, rx_ready); end
  endtask

  task automatic test_wrap();
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < 38; i++) send_byte(8'h61);
    tests_run++; if (cur_x !== 7'd39) begin fails++; $display("FAIL wrap_setup got x=%0d want 39", cur_x); end
    send_byte(8'h42);
    tests_run++; if (we !== 1'b1 || addr_w !== 12'h027 || din !== 7'h42) begin fails++; $display("FAIL wrap_char got we=%0b addr=%h din=%h want 1/027/42", we, addr_w, din); end
    tests_run++; if (cur_x !== 7'd0 || cur_y !== 5'd1 || rx_ready !== 1'b0) begin fails++; $display("FAIL wrap_cursor got (%0d,%0d) rdy=%0b want (0,1) 0", cur_x, cur_y, rx_ready); end
    for (int i = 0; i < 40; i++) begin
      step();
      if (we !== 1'b1 || addr_w !== 12'h080 + 12'(i) || din !== 7'h20 || busy !== 1'b1 || rx_ready !== 1'b0) begin
        bad++; if (first_bad < 0) first_bad = i;
      end
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL wrap_rowclr got %0d bad writes (first idx %0d) want 0", bad, first_bad); end
    step();
    tests_run++; if (we !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin fails++; $display("FAIL wrap_end got we=%0b busy=%0b rdy=%0b want 0/0/1", we, busy, rx_ready); end
  endtask

  task automatic test_lf_wrap();
    int bad = 0;
    for (int i = 0; i < 18; i++) begin send_byte(8'h0A); wait_idle(); end
    for (int i = 0; i < 7; i++) send_byte(8'h2E);
    tests_run++; if (cur_x !== 7'd7 || cur_y !== 5'd19) begin fails++; $display("FAIL lf_setup got (%0d,%0d) want (7,19)", cur_x, cur_y); end
    send_byte(8'h0A);
    tests_run++; if (we !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd0 || busy !== 1'b1) begin fails++; $display("FAIL lf_first got we=%0b (%0d,%0d) busy=%0b want 0 (0,0) 1", we, cur_x, cur_y, busy); end
    for (int i = 0; i < 40; i++) begin
      step();
      if (we !== 1'b1 || addr_w !== 12'(i) || din !== 7'h20) bad++;
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL lf_rowclr got %0d bad writes want 0", bad); end
    step();
    tests_run++; if (we !== 1'b0 || rx_ready !== 1'b1) begin fails++; $display("FAIL lf_end got we=%0b rdy=%0b want 0/1", we, rx_ready); end
  endtask

  task automatic test_backspace();
    for (int i = 0; i < 3; i++) begin send_byte(8'h0A); wait_idle(); end
    for (int i = 0; i < 5; i++) send_byte(8'h2E);
    send_byte(8'h08);
    tests_run++; if (we !== 1'b1 || addr_w !== 12'h184 || din !== 7'h20) begin fails++; $display("FAIL bs_write got we=%0b addr=%h din=%h want 1/184/20", we, addr_w, din); end
    tests_run++; if (cur_x !== 7'd4 || cur_y !== 5'd3) begin fails++; $display("FAIL bs_cursor got (%0d,%0d) want (4,3)", cur_x, cur_y); end
    send_byte(8'h0D);
    tests_run++; if (we !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd3) begin fails++; $display("FAIL cr got we=%0b (%0d,%0d) want 0 (0,3)", we, cur_x, cur_y); end
    send_byte(8'h08);
    tests_run++; if (we !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd3) begin fails++; $display("FAIL bs_col0 got we=%0b (%0d,%0d) want 0 (0,3)", we, cur_x, cur_y); end
    send_byte(8'h85);
    tests_run++; if (we !== 1'b0 || cur_x !== 7'd0 || busy !== 1'b0) begin fails++; $display("FAIL high_byte got we=%0b x=%0d busy=%0b want 0/0/0", we, cur_x, busy); end
    send_byte(8'h7F);
    tests_run++; if (we !== 1'b0 || cur_x !== 7'd0) begin fails++; $display("FAIL del_byte got we=%0b x=%0d want 0/0", we, cur_x); end
  endtask

  task automatic test_clear();
    int bad = 0;
    int nwe = 0;
    logic [11:0] exp_addr;
    send_byte(8'h5A);
    rx_valid = 1'b1; rx_data = 8'h41; clear = 1'b1; #1;
    tests_run++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL clear_blocks_rx got rdy=%0b want 0", rx_ready); end
    step();
    rx_valid = 1'b0; clear = 1'b0;
    tests_run++; if (we !== 1'b0 || busy !== 1'b1 || cur_x !== 7'd1) begin fails++; $display("FAIL clear_start got we=%0b busy=%0b x=%0d want 0/1/1", we, busy, cur_x); end
    for (int i = 0; i < 800; i++) begin
      step();
      clear = 1'b0;
      exp_addr = {5'(i / 40), 7'(i % 40)};
      if (we !== 1'b1 || addr_w !== exp_addr || din !== 7'h20) bad++;
      if (i == 100) clear = 1'b1;
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL scrclr_writes got %0d bad writes want 0", bad); end
    tests_run++; if (addr_w !== 12'h9A7) begin fails++; $display("FAIL scrclr_last got %h want 9A7", addr_w); end
    step();
    tests_run++; if (we !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd0 || rx_ready !== 1'b0) begin fails++; $display("FAIL scrclr_end got we=%0b (%0d,%0d) rdy=%0b want 0 (0,0) 0", we, cur_x, cur_y, rx_ready); end
    step();
    tests_run++; if (we !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL second_start got we=%0b busy=%0b want 0/1", we, busy); end
    for (int i = 0; i < 900 && (we === 1'b1 || nwe == 0); i++) begin
      step();
      if (we === 1'b1) nwe++;
    end
    tests_run++; if (nwe != 800) begin fails++; $display("FAIL second_count got %0d writes want 800", nwe); end
    nwe = 0;
    for (int i = 0; i < 20; i++) begin step(); if (we !== 1'b0 || busy !== 1'b0) nwe++; end
    tests_run++; if (nwe != 0 || rx_ready !== 1'b1) begin fails++; $display("FAIL no_third got %0d active cycles rdy=%0b want 0/1", nwe, rx_ready); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send_byte(8'h51);
    send_byte(8'h0C);
    for (int i = 0; i < 300; i++) step();
    tests_run++; if (we !== 1'b1 || cur_x !== 7'd1) begin fails++; $display("FAIL mid_sweep got we=%0b x=%0d want 1/1", we, cur_x); end
    #2 reset = 1'b0; #1;
    tests_run++; if (we !== 1'b0 || busy !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd0) begin fails++; $display("FAIL async_reset got we=%0b busy=%0b (%0d,%0d) want 0/0 (0,0)", we, busy, cur_x, cur_y); end
    step();
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin step(); if (we !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) bad++; end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL no_resume got %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_printable();
    test_wrap();
    test_lf_wrap();
    test_backspace();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
